// File: rtl/tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tdm_demux_4ch
//
// Receive side of a four-slot TDM link. Incoming qualified words are collected
// into three shadow registers plus the slot-3 word itself, and a completed
// frame is copied to the four channel outputs on a single edge. The outputs
// therefore always hold one coherent frame and never show a partial frame.
// Frame alignment comes from the fsync marker on slot 0. A two-state FSM
// (HUNT / LOCKED) discards data until the first marker arrives. It reports
// framing violations on sync_err.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        slot word, W bits, meaningful only while din_vld=1
//   din_vld    qualifies din; low cycles are gaps and freeze all framing state
//   fsync      marks the qualified word as slot 0
//   out0..out3 channel words of the last complete frame
//   frame_vld  one-cycle pulse when out0..out3 were just updated
//   locked     high while the FSM is LOCKED
//   sync_err   one-cycle pulse after any framing violation
// -----------------------------------------------------------------------------
module tdm_demux_4ch #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_vld,
    input  logic         fsync,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic         frame_vld,
    output logic         locked,
    output logic         sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t       state, state_nxt;
    logic [1:0]   slot, slot_nxt;
    logic [W-1:0] sh0, sh1, sh2;
    logic [W-1:0] sh0_nxt, sh1_nxt, sh2_nxt;
    logic         load_outs;
    logic         frame_vld_nxt;
    logic         sync_err_nxt;

    // Framing decisions for the current word. Everything holds unless a
    // qualified word arrives. An early fsync restarts the frame at slot 0
    // and stays LOCKED. A missing fsync at slot 0 drops back to HUNT,
    // because alignment can no longer be trusted.
    always_comb begin
        state_nxt     = state;
        slot_nxt      = slot;
        sh0_nxt       = sh0;
        sh1_nxt       = sh1;
        sh2_nxt       = sh2;
        load_outs     = 1'b0;
        frame_vld_nxt = 1'b0;
        sync_err_nxt  = 1'b0;

        if (din_vld) begin
            unique case (state)
                HUNT: begin
                    if (fsync) begin
                        sh0_nxt   = din;
                        slot_nxt  = 2'd1;
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (fsync) begin
                        sync_err_nxt = (slot != 2'd0);
                        sh0_nxt      = din;
                        slot_nxt     = 2'd1;
                    end else begin
                        unique case (slot)
                            2'd0: begin
                                sync_err_nxt = 1'b1;
                                slot_nxt     = 2'd0;
                                state_nxt    = HUNT;
                            end
                            2'd1: begin
                                sh1_nxt  = din;
                                slot_nxt = 2'd2;
                            end
                            2'd2: begin
                                sh2_nxt  = din;
                                slot_nxt = 2'd3;
                            end
                            2'd3: begin
                                load_outs     = 1'b1;
                                frame_vld_nxt = 1'b1;
                                slot_nxt      = 2'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Framing state: FSM, slot counter and the shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            slot  <= 2'd0;
            sh0   <= '0;
            sh1   <= '0;
            sh2   <= '0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            sh0   <= sh0_nxt;
            sh1   <= sh1_nxt;
            sh2   <= sh2_nxt;
        end
    end

    // Channel outputs and status pulses. The slot-3 word goes straight to
    // out3, so all four channels change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            frame_vld <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            if (load_outs) begin
                out0 <= sh0;
                out1 <= sh1;
                out2 <= sh2;
                out3 <= din;
            end
            frame_vld <= frame_vld_nxt;
            sync_err  <= sync_err_nxt;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_4ch
//
// Testbench for tdm_demux_4ch with W=8. Vectors are one-clock records of
// inputs together with the hand-computed outputs expected just after that edge.
// Hand-written sequences follow for random gaps and for reset mid-frame.
// -----------------------------------------------------------------------------
module tb_tdm_demux_4ch;

    localparam int W = 8;

    localparam logic [31:0] F_ZERO = 32'h00000000;
    localparam logic [31:0] F_A    = 32'hA0B1C2D3;
    localparam logic [31:0] F_1    = 32'h10111213;
    localparam logic [31:0] F_55   = 32'h55667788;
    localparam logic [31:0] F_2    = 32'h21222324;
    localparam logic [31:0] F_4    = 32'h41424344;
    localparam logic [31:0] F_6    = 32'h61626364;
    localparam logic [31:0] F_E    = 32'hE0E1E2E3;
    localparam logic [31:0] F_8    = 32'h81828384;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_vld;
    logic         fsync;
    logic [W-1:0] out0, out1, out2, out3;
    logic         frame_vld;
    logic         locked;
    logic         sync_err;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        vld;
        logic        fs;
        logic [7:0]  d;
        logic [31:0] outs;
        logic        fv;
        logic        se;
        logic        lk;
    } vec_t;

    vec_t vecs[$];

    tdm_demux_4ch #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .fsync     (fsync),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .frame_vld (frame_vld),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    // 100 MHz-style clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    function automatic void addVec(input logic vld, input logic fs, input logic [7:0] d,
                                   input logic [31:0] outs, input logic fv,
                                   input logic se, input logic lk);
        vec_t v;
        v.vld  = vld;
        v.fs   = fs;
        v.d    = d;
        v.outs = outs;
        v.fv   = fv;
        v.se   = se;
        v.lk   = lk;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int idx, input logic [31:0] outs,
                            input logic fv, input logic se, input logic lk);
        checkOutput({tag, ".outs"}, idx, {out0, out1, out2, out3}, outs);
        checkOutput({tag, ".frame_vld"}, idx, {31'd0, frame_vld}, {31'd0, fv});
        checkOutput({tag, ".sync_err"}, idx, {31'd0, sync_err}, {31'd0, se});
        checkOutput({tag, ".locked"}, idx, {31'd0, locked}, {31'd0, lk});
    endtask

    // Drive one cycle of inputs, then step to just after the next rising edge.
    task automatic applyStimulus(input logic vld, input logic fs, input logic [7:0] d);
        din_vld = vld;
        fsync   = fs;
        din     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gaps;

        // Hunt: words without fsync (and a gap) are dropped silently.
        addVec(1, 0, 8'h11, F_ZERO, 0, 0, 0);
        addVec(1, 0, 8'h22, F_ZERO, 0, 0, 0);
        addVec(0, 0, 8'h33, F_ZERO, 0, 0, 0);
        addVec(1, 0, 8'h44, F_ZERO, 0, 0, 0);
        // First aligned frame, then a back-to-back frame 4 cycles later.
        addVec(1, 1, 8'hA0, F_ZERO, 0, 0, 1);
        addVec(1, 0, 8'hB1, F_ZERO, 0, 0, 1);
        addVec(1, 0, 8'hC2, F_ZERO, 0, 0, 1);
        addVec(1, 0, 8'hD3, F_A,    1, 0, 1);
        addVec(1, 1, 8'h10, F_A,    0, 0, 1);
        addVec(1, 0, 8'h11, F_A,    0, 0, 1);
        addVec(1, 0, 8'h12, F_A,    0, 0, 1);
        addVec(1, 0, 8'h13, F_1,    1, 0, 1);
        // Frame with gaps; fsync during a gap must be ignored.
        addVec(0, 1, 8'hFF, F_1,    0, 0, 1);
        addVec(1, 1, 8'hA0, F_1,    0, 0, 1);
        addVec(0, 0, 8'h00, F_1,    0, 0, 1);
        addVec(0, 0, 8'h00, F_1,    0, 0, 1);
        addVec(1, 0, 8'hB1, F_1,    0, 0, 1);
        addVec(1, 0, 8'hC2, F_1,    0, 0, 1);
        addVec(0, 0, 8'h00, F_1,    0, 0, 1);
        addVec(0, 1, 8'h00, F_1,    0, 0, 1);
        addVec(0, 0, 8'h00, F_1,    0, 0, 1);
        addVec(1, 0, 8'hD3, F_A,    1, 0, 1);
        addVec(0, 0, 8'h00, F_A,    0, 0, 1);
        // Early sync at slot 2.
        addVec(1, 1, 8'h01, F_A,    0, 0, 1);
        addVec(1, 0, 8'h02, F_A,    0, 0, 1);
        addVec(1, 1, 8'h55, F_A,    0, 1, 1);
        addVec(1, 0, 8'h66, F_A,    0, 0, 1);
        addVec(1, 0, 8'h77, F_A,    0, 0, 1);
        addVec(1, 0, 8'h88, F_55,   1, 0, 1);
        // Missing sync at slot 0, then relock.
        addVec(1, 0, 8'h99, F_55,   0, 1, 0);
        addVec(1, 0, 8'hAA, F_55,   0, 0, 0);
        addVec(1, 1, 8'h21, F_55,   0, 0, 1);
        addVec(1, 0, 8'h22, F_55,   0, 0, 1);
        addVec(1, 0, 8'h23, F_55,   0, 0, 1);
        addVec(1, 0, 8'h24, F_2,    1, 0, 1);
        // Early sync at slot 1.
        addVec(1, 1, 8'h31, F_2,    0, 0, 1);
        addVec(1, 1, 8'h41, F_2,    0, 1, 1);
        addVec(1, 0, 8'h42, F_2,    0, 0, 1);
        addVec(1, 0, 8'h43, F_2,    0, 0, 1);
        addVec(1, 0, 8'h44, F_4,    1, 0, 1);
        // Early sync at slot 3: the partial frame must not reach the outputs.
        addVec(1, 1, 8'h51, F_4,    0, 0, 1);
        addVec(1, 0, 8'h52, F_4,    0, 0, 1);
        addVec(1, 0, 8'h53, F_4,    0, 0, 1);
        addVec(1, 1, 8'h61, F_4,    0, 1, 1);
        addVec(1, 0, 8'h62, F_4,    0, 0, 1);
        addVec(1, 0, 8'h63, F_4,    0, 0, 1);
        addVec(1, 0, 8'h64, F_6,    1, 0, 1);

        rst_n   = 1'b0;
        din_vld = 1'b0;
        fsync   = 1'b0;
        din     = '0;
        #3;
        checkAll("reset", 0, F_ZERO, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].vld, vecs[i].fs, vecs[i].d);
            checkAll("vec", i, vecs[i].outs, vecs[i].fv, vecs[i].se, vecs[i].lk);
        end

        // Random 0..3-cycle gaps between the words of one frame.
        for (int i = 0; i < 4; i++) begin
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
                checkAll("gap", i, F_6, 0, 0, 1);
            end
            applyStimulus(1'b1, (i == 0), 8'hE0 + 8'(i));
            checkAll("gapword", i, (i == 3) ? F_E : F_6, (i == 3), 0, 1);
        end

        // Reset in the middle of a frame clears everything without a pulse.
        applyStimulus(1'b1, 1'b1, 8'h71);
        applyStimulus(1'b1, 1'b0, 8'h72);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("rstmid", 0, F_ZERO, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 8'h73);
        checkAll("rsthold", 0, F_ZERO, 0, 0, 0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h73);
        checkAll("rsthunt", 0, F_ZERO, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 8'h81);
        checkAll("rstfr", 0, F_ZERO, 0, 0, 1);
        applyStimulus(1'b1, 1'b0, 8'h82);
        applyStimulus(1'b1, 1'b0, 8'h83);
        checkAll("rstfr", 2, F_ZERO, 0, 0, 1);
        applyStimulus(1'b1, 1'b0, 8'h84);
        checkAll("rstfr", 3, F_8, 1, 0, 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkAll("rstfr", 4, F_8, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4ch.md
# tdm_demux_4ch

Four-channel time-division demultiplexer: the receive-side counterpart of the team's 4:1 multiplexer. It takes the serialized slot stream a rotating-select 4:1 mux produces, tracks frame alignment with a slot counter and a frame-sync marker, and reassembles each complete frame into four registered channel outputs. Outputs update atomically once per complete frame. It sits at the far end of a TDM link, directly after the link's data/valid/sync signals.

## Interface
- W, default 1: slot word width in bits; legal range 1..32.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  W  slot word; sampled only when din_vld=1.
- din_vld  in  1  qualifies din as one slot word; low cycles are gaps.
- fsync  in  1  marks the qualified word as slot 0; ignored when din_vld=0.
- out0..out3  out  W each  channel words of the last complete frame.
- frame_vld  out  1  one-cycle pulse; out0..out3 changed this cycle.
- locked  out  1  high while state is LOCKED.
- sync_err  out  1  one-cycle pulse on any framing violation.

## Operation
- Reset values: out0..out3=0, frame_vld=0, sync_err=0, locked=0, state=HUNT, slot counter=0, shadow registers 0..2=0.
- Internal state: 2-bit slot counter `slot`, shadow registers sh0..sh2 (W bits each), 2-state FSM HUNT/LOCKED.
- HUNT state:
  - Words without fsync are discarded silently; no sync_err.
  - A word with din_vld=1 and fsync=1 is written to sh0, slot becomes 1 and the FSM moves to LOCKED.
- LOCKED state, qualified word:
  - slot=0 with fsync=1: sh0<=din, slot<=1.
  - slot=1 or 2 with fsync=0: sh[slot]<=din, slot<=slot+1.
  - slot=3 with fsync=0: out0<=sh0, out1<=sh1, out2<=sh2, out3<=din, all on the same edge. frame_vld pulses and slot wraps to 0.
  - fsync=1 at slot≠0 (early sync): sync_err pulses and the partial frame is discarded. The word is taken as a new slot 0 (sh0<=din, slot<=1) and the FSM stays LOCKED.
  - fsync=0 at slot=0 (missing sync): sync_err pulses, the word is discarded, slot<=0 and the FSM goes to HUNT.
- Gaps (din_vld=0) freeze slot, shadows and the FSM for any length.
- out0..out3 hold their last value between frames and across errors. Only a complete frame or reset changes them.
- Partial frames never reach the outputs.
- Reset asserted mid-frame: all state returns to reset values at once, with no frame_vld pulse.

## Timing
- Latency: the slot-3 word is sampled at edge N. out0..out3 and frame_vld=1 are visible after edge N; frame_vld returns to 0 after edge N+1 unless another frame completes.
- Minimum frame period is 4 cycles, giving back-to-back frame_vld pulses every 4 cycles with no gaps.
- sync_err is registered: it is high for the one cycle after the offending edge.
- locked rises after the edge that accepts the first fsync word. It falls after the edge that detects a missing sync.
- rst_n deassertion is not required to be synchronized inside the block. The first edge after deassertion may already accept a word.

## Test plan
- Aligned stream, W=8: continuous din_vld with words A0(fsync),B1,C2,D3 then 10,11,12,13 -> out0..3=A0,B1,C2,D3 with frame_vld one cycle after D3 is sampled; next frame_vld exactly 4 cycles later with 10..13; sync_err never set.
- Gaps: same frame with 0–3 idle cycles inserted randomly between words -> identical outputs; frame_vld one cycle after the last word; out0..3 stable during gaps.
- Hunt: 3 words without fsync after reset -> locked=0, no frame_vld, no sync_err, outputs 0. Then a fsync frame arrives -> locked=1 and the frame is delivered.
- Early sync: fsync at slot 2 after words 01,02 -> sync_err pulse, locked stays 1, previous outputs kept. The new frame 55(fsync),66,77,88 is delivered as 55,66,77,88.
- Missing sync: a complete frame, then a word without fsync at slot 0 -> sync_err pulse, locked=0, outputs unchanged until the next fsync frame completes.
- Reset mid-frame: rst_n low after 2 words -> all outputs 0 immediately (asynchronous); after release, a full fsync frame is delivered correctly with no stale shadow data.
